// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide scalar types: register selects and data words.
package cpu_types_pkg;
  localparam int REG_W  = 5;
  localparam int WORD_W = 32;

  typedef logic [REG_W-1:0]  regbits_t;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/regwb_pkg.sv
// Types shared by the register-file writeback queue and its forwarding lookup.
package regwb_pkg;
  import cpu_types_pkg::*;

  typedef struct packed {
    logic     valid;
    regbits_t sel;
    word_t    dat;
  } wbq_entry_t;

  localparam int WBQ_DEPTH_DEF = 4;
endpackage

// File: rtl/regfile_wb_queue_fwd_lookup.sv
// Combinational youngest-match search over the writeback queue, walking from head
// (oldest) to head+count-1 (youngest); the last valid match wins.
module wbq_fwd_lookup
  import cpu_types_pkg::*;
  import regwb_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH_DEF
) (
  input  wbq_entry_t                 entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [$clog2(DEPTH):0]     count,
  input  logic [4:0]                 sel,
  output logic                       hit,
  output logic [31:0]                dat
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] match;
  logic [PW-1:0]    age_idx [DEPTH];

  // match[k] refers to the k-th oldest occupied slot, so index order is age order
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    assign age_idx[gi] = head + PW'(gi);
    assign match[gi]   = (CW'(gi) < count) &&
                         entries[age_idx[gi]].valid &&
                         (entries[age_idx[gi]].sel == sel);
  end

  always_comb begin
    hit = 1'b0;
    dat = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[k]) begin
        hit = 1'b1;
        dat = entries[age_idx[k]].dat;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_queue.sv
// Register-file write arbiter: ALU writes win, load/multicycle writebacks wait in an
// in-order queue. Read forwarding from the queue is enabled by REGWB_BYPASS_EN.
module regfile_wb_queue
  import cpu_types_pkg::*;
  import regwb_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH_DEF
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     alu_wen,
  input  logic [4:0]               alu_wsel,
  input  logic [31:0]              alu_wdat,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [4:0]               wb_sel,
  input  logic [31:0]              wb_dat,
  input  logic [4:0]               rd_sel1,
  input  logic [4:0]               rd_sel2,
  output logic [31:0]              rd_dat1,
  output logic [31:0]              rd_dat2,
  output logic                     rd_hazard,
  output logic [$clog2(DEPTH):0]   wbq_count,
  output logic                     rf_WEN,
  output logic [4:0]               rf_wsel,
  output logic [31:0]              rf_wdat,
  output logic [4:0]               rf_rsel1,
  output logic [4:0]               rf_rsel2,
  input  logic [31:0]              rf_rdat1,
  input  logic [31:0]              rf_rdat2
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wbq_entry_t    q_reg  [DEPTH];
  wbq_entry_t    q_next [DEPTH];
  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;
  wbq_entry_t    head_entry;
  logic          alu_eff, pop, enq_store;

  assign alu_eff    = alu_wen && (alu_wsel != '0);
  assign wb_ready   = (count_reg < CW'(DEPTH));
  assign enq_store  = wb_valid && wb_ready && (wb_sel != '0);
  assign pop        = !alu_eff && (count_reg != '0);
  assign head_entry = q_reg[head_reg];
  assign wbq_count  = count_reg;

  always_comb begin
    rf_WEN  = 1'b0;
    rf_wsel = alu_wsel;
    rf_wdat = alu_wdat;
    if (alu_eff) begin
      rf_WEN = 1'b1;
    end else if (pop) begin
      rf_WEN  = head_entry.valid;
      rf_wsel = head_entry.sel;
      rf_wdat = head_entry.dat;
    end
  end

  // Kill older same-register entries first; the slot filled this edge is younger
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      q_next[i] = q_reg[i];
      if (alu_eff && q_reg[i].valid && (q_reg[i].sel == alu_wsel))
        q_next[i].valid = 1'b0;
      if (pop && (head_reg == PW'(i)))
        q_next[i].valid = 1'b0;
      if (enq_store && (tail_reg == PW'(i)))
        q_next[i] = '{valid: 1'b1, sel: wb_sel, dat: wb_dat};
    end
  end

  assign head_next  = head_reg + PW'(pop);
  assign tail_next  = tail_reg + PW'(enq_store);
  assign count_next = count_reg + CW'(enq_store) - CW'(pop);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) q_reg[i] <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      for (int i = 0; i < DEPTH; i++) q_reg[i] <= q_next[i];
    end
  end

  assign rf_rsel1 = rd_sel1;
  assign rf_rsel2 = rd_sel2;

  regbits_t   rd_sel_arr  [2];
  word_t      rf_rdat_arr [2];
  word_t      rd_dat_arr  [2];
  word_t      fwd_dat     [2];
  logic [1:0] fwd_hit;
  logic [1:0] hazard_vec;

  assign rd_sel_arr[0]  = rd_sel1;
  assign rd_sel_arr[1]  = rd_sel2;
  assign rf_rdat_arr[0] = rf_rdat1;
  assign rf_rdat_arr[1] = rf_rdat2;
  assign rd_dat1        = rd_dat_arr[0];
  assign rd_dat2        = rd_dat_arr[1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    wbq_fwd_lookup #(.DEPTH(DEPTH)) u_lookup (
      .entries (q_reg),
      .head    (head_reg),
      .count   (count_reg),
      .sel     (rd_sel_arr[gi]),
      .hit     (fwd_hit[gi]),
      .dat     (fwd_dat[gi])
    );

    assign hazard_vec[gi] = fwd_hit[gi] && (rd_sel_arr[gi] != '0);

`ifdef REGWB_BYPASS_EN
    assign rd_dat_arr[gi] = (rd_sel_arr[gi] == '0) ? '0 :
                            fwd_hit[gi]            ? fwd_dat[gi] : rf_rdat_arr[gi];
`else
    assign rd_dat_arr[gi] = (rd_sel_arr[gi] == '0) ? '0 : rf_rdat_arr[gi];
`endif
  end

`ifdef REGWB_BYPASS_EN
  logic unused_hazard;
  assign unused_hazard = |hazard_vec;
  assign rd_hazard     = 1'b0;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_dat[0], fwd_dat[1]};
  assign rd_hazard  = |hazard_vec;
`endif
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue: expected register-file writes are queued as
// stimulus is applied and matched in order against every rf_WEN cycle.
module tb_regfile_wb_queue;
`ifdef REGWB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        alu_wen;
  logic [4:0]  alu_wsel;
  logic [31:0] alu_wdat;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_sel;
  logic [31:0] wb_dat;
  logic [4:0]  rd_sel1, rd_sel2;
  logic [31:0] rd_dat1, rd_dat2;
  logic        rd_hazard;
  logic [2:0]  wbq_count;
  logic        rf_WEN;
  logic [4:0]  rf_wsel;
  logic [31:0] rf_wdat;
  logic [4:0]  rf_rsel1, rf_rsel2;
  logic [31:0] rf_rdat1, rf_rdat2;

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST),
    .alu_wen(alu_wen), .alu_wsel(alu_wsel), .alu_wdat(alu_wdat),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_sel(wb_sel), .wb_dat(wb_dat),
    .rd_sel1(rd_sel1), .rd_sel2(rd_sel2), .rd_dat1(rd_dat1), .rd_dat2(rd_dat2),
    .rd_hazard(rd_hazard), .wbq_count(wbq_count),
    .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
    .rf_rsel1(rf_rsel1), .rf_rsel2(rf_rsel2),
    .rf_rdat1(rf_rdat1), .rf_rdat2(rf_rdat2)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0]  sel;
    logic [31:0] dat;
  } wr_t;

  wr_t         exp_q [$];
  wr_t         acc_q [$];
  logic [31:0] shadow [32];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write monitor: every register-file write must be the next expected one
  always @(negedge CLK) begin
    wr_t e;
    if (nRST === 1'b1 && rf_WEN === 1'b1) begin
      $display("rf write r%0d <= 0x%08h", rf_wsel, rf_wdat);
      shadow[rf_wsel] <= rf_wdat;
      if (exp_q.size() == 0) begin
        check("unexpected_write_sel", {27'd0, rf_wsel}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_sel", {27'd0, rf_wsel}, {27'd0, e.sel});
        check("wr_dat", rf_wdat, e.dat);
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic alu(input logic en, input logic [4:0] s, input logic [31:0] d);
    alu_wen  = en;
    alu_wsel = s;
    alu_wdat = d;
    if (en && s != 5'd0) exp_q.push_back('{sel: s, dat: d});
  endtask

  task automatic wb(input logic v, input logic [4:0] s, input logic [31:0] d);
    wb_valid = v;
    wb_sel   = s;
    wb_dat   = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRST = 1'b0;
    alu_wen = 1'b0; alu_wsel = '0; alu_wdat = '0;
    wb_valid = 1'b0; wb_sel = '0; wb_dat = '0;
    rd_sel1 = '0; rd_sel2 = '0; rf_rdat1 = '0; rf_rdat2 = '0;
    for (int i = 0; i < 32; i++) shadow[i] = '0;

    #2;
    check("reset_count", {29'd0, wbq_count}, 32'd0);
    check("reset_ready", {31'd0, wb_ready}, 32'd1);
    check("reset_wen", {31'd0, rf_WEN}, 32'd0);
    cyc();
    nRST = 1'b1;

    // single writeback drains on the following cycle
    cyc();
    wb(1'b1, 5'd5, 32'hDEADBEEF);
    exp_q.push_back('{sel: 5'd5, dat: 32'hDEADBEEF});
    #1 check("t1_ready", {31'd0, wb_ready}, 32'd1);
    cyc();
    wb(1'b0, 5'd0, 32'd0);
    #1;
    check("t1_count_pending", {29'd0, wbq_count}, 32'd1);
    check("t1_wen", {31'd0, rf_WEN}, 32'd1);
    cyc();
    #1 check("t1_count_drained", {29'd0, wbq_count}, 32'd0);

    // ALU holds the port while five writebacks are offered; only DEPTH fit
    for (int i = 0; i < 5; i++) begin
      alu(1'b1, 5'd9, 32'h99);
      wb(1'b1, 5'(10 + i), 32'h100 + 32'(i));
      #1 check($sformatf("t2_ready_%0d", i), {31'd0, wb_ready}, (i < DEPTH) ? 32'd1 : 32'd0);
      if (i < DEPTH) acc_q.push_back('{sel: 5'(10 + i), dat: 32'h100 + 32'(i)});
      cyc();
    end
    alu(1'b0, 5'd0, 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    while (acc_q.size() > 0) exp_q.push_back(acc_q.pop_front());
    #1;
    check("t2_count_full", {29'd0, wbq_count}, 32'd4);
    check("t2_ready_full", {31'd0, wb_ready}, 32'd0);
    for (int i = 0; i < DEPTH; i++) cyc();
    #1 check("t2_count_drained", {29'd0, wbq_count}, 32'd0);

    // two pending writes to r7: youngest must be the one forwarded
    alu(1'b1, 5'd9, 32'h99);
    wb(1'b1, 5'd7, 32'h11);
    cyc();
    alu(1'b1, 5'd9, 32'h99);
    wb(1'b1, 5'd7, 32'h22);
    cyc();
    alu(1'b1, 5'd9, 32'h99);
    wb(1'b0, 5'd0, 32'd0);
    rd_sel1 = 5'd7; rf_rdat1 = 32'h0;
    rd_sel2 = 5'd0; rf_rdat2 = 32'hFFFFFFFF;
    #1;
    check("t3_count", {29'd0, wbq_count}, 32'd2);
    check("t3_rd1", rd_dat1, BYP ? 32'h22 : 32'h0);
    check("t3_hazard", {31'd0, rd_hazard}, BYP ? 32'd0 : 32'd1);
    check("t3_rd2_zero", rd_dat2, 32'd0);
    check("t3_rsel1", {27'd0, rf_rsel1}, 32'd7);
    rd_sel2 = 5'd8; rf_rdat2 = 32'h5555;
    #1 check("t3_rd2_nomatch", rd_dat2, 32'h5555);
    rd_sel1 = 5'd0; rd_sel2 = 5'd7; rf_rdat2 = 32'h3333;
    #1;
    check("t3_rd2_fwd", rd_dat2, BYP ? 32'h22 : 32'h3333);
    check("t3_hazard2", {31'd0, rd_hazard}, BYP ? 32'd0 : 32'd1);
    check("t3_rd1_zero", rd_dat1, 32'd0);
    cyc();
    alu(1'b0, 5'd0, 32'd0);
    rd_sel1 = 5'd0; rd_sel2 = 5'd0;
    exp_q.push_back('{sel: 5'd7, dat: 32'h11});
    exp_q.push_back('{sel: 5'd7, dat: 32'h22});
    cyc();
    cyc();
    #1 check("t3_count_drained", {29'd0, wbq_count}, 32'd0);

    // ALU write to r3 kills the older queued r3; drain becomes a bubble
    alu(1'b1, 5'd9, 32'h99);
    wb(1'b1, 5'd3, 32'hAA);
    cyc();
    alu(1'b1, 5'd3, 32'hBB);
    wb(1'b0, 5'd0, 32'd0);
    cyc();
    alu(1'b0, 5'd0, 32'd0);
    #1;
    check("t4_count_killed", {29'd0, wbq_count}, 32'd1);
    check("t4_bubble_wen", {31'd0, rf_WEN}, 32'd0);
    cyc();
    #1;
    check("t4_count_drained", {29'd0, wbq_count}, 32'd0);
    check("t4_r3_value", shadow[3], 32'hBB);

    // same-edge enqueue is younger than the ALU write and survives
    alu(1'b1, 5'd4, 32'h44);
    wb(1'b1, 5'd4, 32'h4444);
    cyc();
    alu(1'b0, 5'd0, 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    exp_q.push_back('{sel: 5'd4, dat: 32'h4444});
    cyc();
    #1;
    check("t5_count", {29'd0, wbq_count}, 32'd0);
    check("t5_r4_value", shadow[4], 32'h4444);

    // wb_sel==0 is accepted but not stored
    wb(1'b1, 5'd0, 32'h1234);
    #1 check("t6_ready_sel0", {31'd0, wb_ready}, 32'd1);
    cyc();
    wb(1'b0, 5'd0, 32'd0);
    #1 check("t6_count_sel0", {29'd0, wbq_count}, 32'd0);

    // ALU write to r0 does not block the drain
    alu(1'b1, 5'd9, 32'h99);
    wb(1'b1, 5'd6, 32'h66);
    cyc();
    alu(1'b1, 5'd0, 32'h77);
    wb(1'b0, 5'd0, 32'd0);
    exp_q.push_back('{sel: 5'd6, dat: 32'h66});
    #1 check("t7_wsel_drain", {27'd0, rf_wsel}, 32'd6);
    cyc();
    alu(1'b0, 5'd0, 32'd0);
    #1 check("t7_count", {29'd0, wbq_count}, 32'd0);

    // reset with pending entries discards them
    alu(1'b1, 5'd9, 32'h99);
    wb(1'b1, 5'd12, 32'hC1);
    cyc();
    alu(1'b1, 5'd9, 32'h99);
    wb(1'b1, 5'd13, 32'hC2);
    cyc();
    alu(1'b0, 5'd0, 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    #1 check("t8_count_before_reset", {29'd0, wbq_count}, 32'd2);
    nRST = 1'b0;
    #1;
    check("t8_reset_count", {29'd0, wbq_count}, 32'd0);
    check("t8_reset_ready", {31'd0, wb_ready}, 32'd1);
    check("t8_reset_wen", {31'd0, rf_WEN}, 32'd0);
    cyc();
    nRST = 1'b1;
    cyc(); cyc(); cyc();
    #1;
    check("t8_count_after", {29'd0, wbq_count}, 32'd0);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
